// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, with sign correction and a one-cycle write-back pulse.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  wa,
    output logic        we
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [31:0] opnd;
    logic [63:0] acc;
    logic        neg_res;
    logic        neg_rem;

    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic        div_zero, div_ovf;
    logic [31:0] fast_val;

    // Operand decode and divide special cases, evaluated on the live inputs in IDLE.
    always_comb begin
        a_signed = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed && rs1[31];
        b_neg    = b_signed && rs2[31];
        a_abs    = a_neg ? -rs1 : rs1;
        b_abs    = b_neg ? -rs2 : rs2;
        div_zero = funct3[2] && (rs2 == 32'd0);
        div_ovf  = funct3[2] && !funct3[0] &&
                   (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
        if (div_zero)
            fast_val = funct3[1] ? rs1 : 32'hFFFF_FFFF;
        else
            fast_val = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] acc_nxt;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, final_val;

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, opnd};
        if (op[2]) begin
            if (div_diff[32])
                acc_nxt = {div_shift[31:0], acc[30:0], 1'b0};
            else
                acc_nxt = {div_diff[31:0], acc[30:0], 1'b1};
        end else begin
            acc_nxt = {mul_sum, acc[31:1]};
        end

        prod_fix = neg_res ? -acc_nxt : acc_nxt;
        quo_fix  = neg_res ? -acc_nxt[31:0] : acc_nxt[31:0];
        rem_fix  = neg_rem ? -acc_nxt[63:32] : acc_nxt[63:32];
        case (op)
            3'b000:                 final_val = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: final_val = prod_fix[63:32];
            3'b100, 3'b101:         final_val = quo_fix;
            default:                final_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            op      <= 3'd0;
            rd      <= 5'd0;
            opnd    <= 32'd0;
            acc     <= 64'd0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            result  <= 32'd0;
            wa      <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op <= funct3;
                        rd <= rd_in;
                        if (div_zero || div_ovf) begin
                            result <= fast_val;
                            wa     <= rd_in;
                            state  <= DONE;
                        end else begin
                            opnd    <= funct3[2] ? b_abs : a_abs;
                            acc     <= {32'd0, funct3[2] ? a_abs : b_abs};
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            cnt     <= 6'd0;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        result <= final_val;
                        wa     <= rd;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign we   = done && (wa != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, special cases,
// ignored start, x0 destination, mid-operation reset and a few model-checked random ops.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd_in;
    logic        busy, done, we;
    logic [31:0] result;
    logic [4:0]  wa;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
        logic        we;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .wa     (wa),
        .we     (we)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Reference model written directly from RV32M semantics using wide signed arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic [31:0] expRes, input int lat,
                                 input bit junk);
        exp_t e;
        @(negedge clk);
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        rd_in  = rd;
        start  = 1'b1;
        e.res  = expRes;
        e.wa   = rd;
        e.we   = (rd != 5'd0);
        e.lat  = lat;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (junk) begin
            funct3 = ~f3;
            rs1    = ~a;
            rs2    = b + 32'd5;
            rd_in  = rd + 5'd1;
        end else begin
            start = 1'b0;
        end
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        int   k;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_latency"}, 32'(k), 32'(e.lat));
        check({tag, "_result"}, result, e.res);
        check({tag, "_wa"}, 32'(wa), 32'(e.wa));
        check({tag, "_we"}, 32'(we), 32'(e.we));
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_after"}, 32'(done), 32'd0);
        check({tag, "_result_hold"}, result, e.res);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        funct3 = 3'd0;
        rs1    = 32'd0;
        rs2    = 32'd0;
        rd_in  = 5'd0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_we", 32'(we), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_wa", 32'(wa), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 32, 1'b0);
        checkOutput("mul");
        applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 32, 1'b0);
        checkOutput("mulh");
        applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 32, 1'b0);
        checkOutput("mulhu");
        applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 32, 1'b0);
        checkOutput("mulhsu");
        applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 32, 1'b0);
        checkOutput("div_neg");
        applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 32, 1'b0);
        checkOutput("rem_neg");
        applyStimulus(3'b101, 32'd100, 32'd7, 5'd7, 32'd14, 32, 1'b0);
        checkOutput("divu");
        applyStimulus(3'b111, 32'd100, 32'd7, 5'd8, 32'd2, 32, 1'b0);
        checkOutput("remu");

        applyStimulus(3'b100, 32'd9, 32'd0, 5'd9, 32'hFFFF_FFFF, 0, 1'b0);
        checkOutput("div_by_zero");
        applyStimulus(3'b111, 32'd5, 32'd0, 5'd10, 32'd5, 0, 1'b0);
        checkOutput("remu_by_zero");
        applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0, 1'b0);
        checkOutput("div_overflow");
        applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 0, 1'b0);
        checkOutput("rem_overflow");

        applyStimulus(3'b000, 32'd5, 32'd0, 5'd14, 32'd0, 32, 1'b0);
        checkOutput("mul_by_zero");
        applyStimulus(3'b000, 32'd6, 32'd7, 5'd13, 32'd42, 32, 1'b1);
        checkOutput("ignored_start");
        applyStimulus(3'b101, 32'd50, 32'd5, 5'd0, 32'd10, 32, 1'b0);
        checkOutput("x0_dest");

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            logic [4:0]  rd;
            int          lat;
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = (i == 3) ? 32'd0 : $urandom;
            rd  = 5'($urandom_range(0, 31));
            lat = (f3[2] && ((b == 32'd0) ||
                  (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 0 : 32;
            applyStimulus(f3, a, b, rd, refModel(f3, a, b), lat, 1'b0);
            checkOutput("random");
        end

        applyStimulus(3'b100, 32'd1000, 32'd3, 5'd15, 32'd333, 32, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_we", 32'(we), 32'd0);
        check("midreset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int pulses;
            pulses = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) pulses++;
            end
            check("midreset_no_writeback", 32'(pulses), 32'd0);
        end
        applyStimulus(3'b000, 32'd3, 32'd4, 5'd16, 32'd12, 32, 1'b0);
        checkOutput("mul_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
